e203_ifu_pcgen_oq: RTL and testbench

//  Parametrised fetch-PC generator with outstanding-request tracking for the IFU.

---
 rtl/e203_ifu_pcgen_oq_if.sv | 28 ++
 rtl/e203_ifu_pcgen_oq.sv | 80 ++++++++
 tb/tb_e203_ifu_pcgen_oq.sv | 135 +++++++++++++
 3 files changed

// File: rtl/e203_ifu_pcgen_oq_if.sv
// e203_ifu_pcgen_oq_if: fetch request, fetch response and decode-side handshakes of the IFU PC generator.
interface e203_ifu_pcgen_oq_if #(
    parameter int PC_SIZE = 32,
    parameter int INSTR_W = 32
);
    logic               req_valid;
    logic               req_ready;
    logic [PC_SIZE-1:0] req_pc;
    logic               req_seq;
    logic [PC_SIZE-1:0] req_last_pc;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_err;
    logic [INSTR_W-1:0] rsp_instr;
    logic               o_valid;
    logic               o_ready;
    logic [PC_SIZE-1:0] o_pc;
    logic [INSTR_W-1:0] o_instr;
    logic               o_buserr;
    modport master (
        output req_valid, req_pc, req_seq, req_last_pc, rsp_ready, o_valid, o_pc, o_instr, o_buserr,
        input  req_ready, rsp_valid, rsp_err, rsp_instr, o_ready
    );
    modport slave (
        input  req_valid, req_pc, req_seq, req_last_pc, rsp_ready, o_valid, o_pc, o_instr, o_buserr,
        output req_ready, rsp_valid, rsp_err, rsp_instr, o_ready
    );
endinterface

// File: rtl/e203_ifu_pcgen_oq.sv
// e203_ifu_pcgen_oq: fetch-PC generator with in-order outstanding tracking and stale-response dropping.
module e203_ifu_pcgen_oq #(
    parameter int PC_SIZE     = 32,
    parameter int OUTS_DEPTH  = 2,
    parameter int CNT_W       = 2,
    parameter int FETCH_BYTES = 4,
    parameter int INSTR_W     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_SIZE-1:0]  pc_rtvec,
    e203_ifu_pcgen_oq_if.master bus,
    input  logic                flush_req,
    input  logic [PC_SIZE-1:0]  flush_pc,
    output logic                flush_ack,
    input  logic                redir_valid,
    input  logic [PC_SIZE-1:0]  redir_pc,
    input  logic                halt_req,
    output logic                halt_ack,
    output logic [CNT_W-1:0]    outs_cnt_o
);
    logic               boot_r, boot_req_r, pend_r;
    logic [PC_SIZE-1:0] pc_r, last_pc, tgt;
    logic [CNT_W-1:0]   outs_cnt, kill_cnt;
    logic [PC_SIZE-1:0] fifo [OUTS_DEPTH];
    logic [INSTR_W-1:0] instr;
    logic               chg, kill, req_hsk, rsp_hsk;

    assign chg             = flush_req | redir_valid;
    assign tgt             = flush_req ? flush_pc : redir_valid ? redir_pc : boot_req_r ? pc_rtvec : pc_r;
    assign bus.req_pc      = {tgt[PC_SIZE-1:1], 1'b0};
    assign bus.req_seq     = ~(chg | boot_req_r | pend_r);
    assign bus.req_last_pc = last_pc;
    assign bus.req_valid   = ~boot_r & (flush_req | ~halt_req) & (outs_cnt < CNT_W'(OUTS_DEPTH));
    assign req_hsk         = bus.req_valid & bus.req_ready;
    // While stale responses are pending they are swallowed without reaching decode.
    assign kill            = |kill_cnt;
    assign bus.rsp_ready   = kill | bus.o_ready;
    assign bus.o_valid     = ~kill & ~boot_r & bus.rsp_valid;
    assign rsp_hsk         = bus.rsp_valid & bus.rsp_ready;
    assign instr           = bus.rsp_instr;
    assign bus.o_instr     = instr;
    assign bus.o_buserr    = bus.rsp_err;
    assign bus.o_pc        = fifo[0];
    assign flush_ack       = flush_req;
    assign halt_ack        = halt_req & ~|outs_cnt & ~bus.req_valid;
    assign outs_cnt_o      = outs_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            boot_r     <= 1'b1;
            boot_req_r <= 1'b0;
            pend_r     <= 1'b0;
            pc_r       <= '0;
            last_pc    <= '0;
            outs_cnt   <= '0;
            kill_cnt   <= '0;
            for (int i = 0; i < OUTS_DEPTH; i++) fifo[i] <= '0;
        end else begin
            boot_r     <= 1'b0;
            boot_req_r <= boot_r | (boot_req_r & ~req_hsk);
            if (req_hsk) begin
                pc_r    <= (bus.req_pc & ~PC_SIZE'(FETCH_BYTES - 1)) + PC_SIZE'(FETCH_BYTES);
                last_pc <= bus.req_pc;
                pend_r  <= 1'b0;
            end else if (chg) begin
                pc_r   <= bus.req_pc;
                pend_r <= 1'b1;
            end
            outs_cnt <= outs_cnt + CNT_W'(req_hsk) - CNT_W'(rsp_hsk);
            // A request accepted in the redirect cycle already carries the new target, so it is not counted.
            if (chg) kill_cnt <= outs_cnt - CNT_W'(rsp_hsk);
            else if (kill & rsp_hsk) kill_cnt <= kill_cnt - CNT_W'(1);
            if (rsp_hsk) for (int i = 0; i < OUTS_DEPTH - 1; i++) fifo[i] <= fifo[i+1];
            if (req_hsk) fifo[outs_cnt - CNT_W'(rsp_hsk)] <= bus.req_pc;
        end
    end

    rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n) bus.rsp_valid |-> outs_cnt != '0);
endmodule

// File: tb/tb_e203_ifu_pcgen_oq.sv
// tb_e203_ifu_pcgen_oq: cycle-by-cycle directed vectors for the fetch-PC generator.
module tb_e203_ifu_pcgen_oq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_rtvec = 32'h8000_0000;
    logic        flush_req = 1'b0, redir_valid = 1'b0, halt_req = 1'b0;
    logic [31:0] flush_pc = '0, redir_pc = '0;
    logic        flush_ack, halt_ack;
    logic [1:0]  outs_cnt_o;
    int          n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    e203_ifu_pcgen_oq_if #(.PC_SIZE(32), .INSTR_W(32)) bus ();

    e203_ifu_pcgen_oq #(.PC_SIZE(32), .OUTS_DEPTH(2), .CNT_W(2), .FETCH_BYTES(4), .INSTR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec), .bus(bus),
        .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .halt_req(halt_req), .halt_ack(halt_ack), .outs_cnt_o(outs_cnt_o)
    );

    typedef struct {
        logic rr, rv, ordy, fl; logic [31:0] fpc; logic rd; logic [31:0] rpc; logic hl;
        logic [31:0] instr; logic err;
        logic qv; logic [31:0] qpc; logic qs; logic [31:0] lpc;
        logic ov; logic [31:0] opc; logic rrdy; logic [1:0] cnt; logic hack;
    } vec_t;
    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        //           rr rv or fl fpc          rd rpc   hl instr        err | qv qpc          qs lpc          ov opc          rrdy cnt hack
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  0, 0,           1, 0,           0, 0,           0,   0,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h80000000,  0, 0,           0, 0,           0,   0,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h80000004,  1, 'h80000000,  0, 0,           0,   1,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  0, 'h80000008,  1, 'h80000004,  0, 0,           0,   2,  0});
        vq.push_back('{1, 1, 1, 0, 0,           0, 0,    0, 'h11111111,  0,  0, 'h80000008,  1, 'h80000004,  1, 'h80000000,  1,   2,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h80000008,  1, 'h80000004,  0, 0,           0,   1,  0});
        vq.push_back('{1, 0, 0, 1, 'h100,       0, 0,    0, 0,           0,  0, 'h100,       0, 'h80000008,  0, 0,           0,   2,  0});
        vq.push_back('{0, 1, 0, 0, 0,           0, 0,    0, 'h22222222,  0,  0, 'h100,       0, 'h80000008,  0, 0,           1,   2,  0});
        vq.push_back('{1, 1, 0, 0, 0,           0, 0,    0, 'h22222222,  0,  1, 'h100,       0, 'h80000008,  0, 0,           1,   1,  0});
        vq.push_back('{0, 1, 1, 0, 0,           0, 0,    0, 'h33333333,  1,  1, 'h104,       1, 'h100,       1, 'h100,       1,   1,  0});
        vq.push_back('{0, 0, 0, 1, 'h202,       0, 0,    0, 0,           0,  1, 'h202,       0, 'h100,       0, 0,           0,   0,  0});
        vq.push_back('{0, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h202,       0, 'h100,       0, 0,           0,   0,  0});
        vq.push_back('{0, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h202,       0, 'h100,       0, 0,           0,   0,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h202,       0, 'h100,       0, 0,           0,   0,  0});
        vq.push_back('{0, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h204,       1, 'h202,       0, 0,           0,   1,  0});
        vq.push_back('{1, 0, 0, 1, 'h40,        1, 'h80, 0, 0,           0,  1, 'h40,        0, 'h202,       0, 0,           0,   1,  0});
        vq.push_back('{0, 1, 0, 0, 0,           0, 0,    0, 0,           0,  0, 'h44,        1, 'h40,        0, 0,           1,   2,  0});
        vq.push_back('{0, 0, 0, 0, 0,           1, 'h80, 0, 0,           0,  1, 'h80,        0, 'h40,        0, 0,           0,   1,  0});
        vq.push_back('{0, 1, 1, 0, 0,           0, 0,    0, 0,           0,  1, 'h80,        0, 'h40,        0, 0,           1,   1,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h80,        0, 'h40,        0, 0,           0,   0,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    1, 0,           0,  0, 'h84,        1, 'h80,        0, 0,           0,   1,  0});
        vq.push_back('{1, 1, 1, 0, 0,           0, 0,    1, 'h44444444,  0,  0, 'h84,        1, 'h80,        1, 'h80,        1,   1,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    1, 0,           0,  0, 'h84,        1, 'h80,        0, 0,           0,   0,  1});
        vq.push_back('{0, 0, 0, 1, 'h300,       0, 0,    1, 0,           0,  1, 'h300,       0, 'h80,        0, 0,           0,   0,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h300,       0, 'h80,        0, 0,           0,   0,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h304,       1, 'h300,       0, 0,           0,   1,  0});
        vq.push_back('{1, 1, 1, 1, 'h500,       0, 0,    0, 'h55555555,  0,  0, 'h500,       0, 'h304,       1, 'h300,       1,   2,  0});
        vq.push_back('{1, 1, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h500,       0, 'h304,       0, 0,           1,   1,  0});
        vq.push_back('{0, 1, 1, 0, 0,           0, 0,    0, 'h66666666,  0,  1, 'h504,       1, 'h500,       1, 'h500,       1,   1,  0});
        vq.push_back('{1, 0, 0, 1, 'hFFFFFFFF,  0, 0,    0, 0,           0,  1, 'hFFFFFFFE,  0, 'h500,       0, 0,           0,   0,  0});
        vq.push_back('{1, 0, 0, 0, 0,           0, 0,    0, 0,           0,  1, 'h00000000,  1, 'hFFFFFFFE,  0, 0,           0,   1,  0});

        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.o_ready = 1'b0;
        bus.rsp_err = 1'b0; bus.rsp_instr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst req_valid", 32'(bus.req_valid), 0);
        chk("rst o_valid", 32'(bus.o_valid), 0);
        chk("rst outs_cnt", 32'(outs_cnt_o), 0);
        chk("rst last_pc", bus.req_last_pc, 0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            bus.req_ready = vq[i].rr; bus.rsp_valid = vq[i].rv; bus.o_ready = vq[i].ordy;
            flush_req = vq[i].fl; flush_pc = vq[i].fpc; redir_valid = vq[i].rd; redir_pc = vq[i].rpc;
            halt_req = vq[i].hl; bus.rsp_instr = vq[i].instr; bus.rsp_err = vq[i].err;
            #1;
            chk($sformatf("row%0d req_valid", i), 32'(bus.req_valid), 32'(vq[i].qv));
            chk($sformatf("row%0d req_pc", i), bus.req_pc, vq[i].qpc);
            chk($sformatf("row%0d req_seq", i), 32'(bus.req_seq), 32'(vq[i].qs));
            chk($sformatf("row%0d req_last_pc", i), bus.req_last_pc, vq[i].lpc);
            chk($sformatf("row%0d o_valid", i), 32'(bus.o_valid), 32'(vq[i].ov));
            chk($sformatf("row%0d rsp_ready", i), 32'(bus.rsp_ready), 32'(vq[i].rrdy));
            chk($sformatf("row%0d outs_cnt", i), 32'(outs_cnt_o), 32'(vq[i].cnt));
            chk($sformatf("row%0d halt_ack", i), 32'(halt_ack), 32'(vq[i].hack));
            chk($sformatf("row%0d flush_ack", i), 32'(flush_ack), 32'(vq[i].fl));
            if (vq[i].ov) begin
                chk($sformatf("row%0d o_pc", i), bus.o_pc, vq[i].opc);
                chk($sformatf("row%0d o_instr", i), bus.o_instr, vq[i].instr);
                chk($sformatf("row%0d o_buserr", i), 32'(bus.o_buserr), 32'(vq[i].err));
            end
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of a burst, then a fresh boot sequence.
        bus.req_ready = 1'b1; bus.rsp_valid = 1'b0; bus.o_ready = 1'b0;
        flush_req = 1'b0; redir_valid = 1'b0; halt_req = 1'b0;
        #1;
        chk("burst outs_cnt", 32'(outs_cnt_o), 2);
        rst_n = 1'b0;
        #1;
        chk("midrst outs_cnt", 32'(outs_cnt_o), 0);
        chk("midrst req_valid", 32'(bus.req_valid), 0);
        chk("midrst last_pc", bus.req_last_pc, 0);
        chk("midrst req_pc", bus.req_pc, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("reboot c1 req_valid", 32'(bus.req_valid), 0);
        @(posedge clk);
        #1;
        chk("reboot c2 req_valid", 32'(bus.req_valid), 1);
        chk("reboot c2 req_pc", bus.req_pc, 32'h8000_0000);
        chk("reboot c2 req_seq", 32'(bus.req_seq), 0);
        @(posedge clk);
        #1;
        chk("reboot c3 req_pc", bus.req_pc, 32'h8000_0004);
        chk("reboot c3 req_seq", 32'(bus.req_seq), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
